key_debounce: RTL and testbench
===============================

# key_debounce

Conditions the board's active-low push buttons for the Nios II system. Each key is synchronized into the 50 MHz domain, debounced with a per-key stability counter, and turned into a clean level, one-cycle press/release pulses, and sticky press flags with an acknowledge handshake. It sits upstream of the SoC: its outputs drive PIO input exports and fabric logic, in place of raw KEY wiring.

## Interface
- NUM_KEYS, 2, number of independent key channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a level change is accepted (20 ms at 50 MHz); legal range 2..2^CNT_WIDTH.
- CNT_WIDTH, 20, width of each per-key counter; must hold DEBOUNCE_CYCLES-1.

- clk  input  1  system clock (MAX10_CLK1_50).
- reset  input  1  asynchronous, active-high reset.
- key_n  input  NUM_KEYS  raw active-low buttons, asynchronous to clk.
- ack  input  NUM_KEYS  per-key clear of press_flag, sampled each clk edge.
- key_level  output  NUM_KEYS  debounced state, 1 = pressed.
- key_press  output  NUM_KEYS  one-cycle pulse on an accepted press.
- key_release  output  NUM_KEYS  one-cycle pulse on an accepted release.
- press_flag  output  NUM_KEYS  sticky: set by key_press, cleared by ack.

## Operation
- Reset values: sync flops 0 (inverted idle key), counters 0, key_level 0, key_press 0, key_release 0, press_flag 0.
- Per key i, all channels independent and identical:
  - Synchronizer: two flops on ~key_n[i]; the second stage is s[i]. No logic between the stages.
  - State IDLE (s == key_level, counter 0): hold.
  - State COUNT (s != key_level): counter increments each edge.
  - If s returns to key_level before acceptance: counter clears to 0 at that edge, back to IDLE. No pulse.
  - Acceptance: at an edge where s != key_level and counter == DEBOUNCE_CYCLES-1, key_level toggles, counter clears, and key_press (new level 1) or key_release (new level 0) is driven high for exactly the following cycle.
  - The counter never wraps. The acceptance compare prevents overflow.
- press_flag[i] next value = key_press[i] | (press_flag[i] & ~ack[i]).
  - Set and ack on the same edge: set wins and the flag stays 1.
  - ack while the flag is 0: no effect.
  - ack held high: the flag clears and stays clear. A later press still sets it for at least one cycle.
- Asserting reset mid-count discards the count and all pending state. After release, a key still held re-debounces from 0 and produces a fresh key_press.

## Timing
- Let edge k be the first clk edge that samples a new key_n value. s changes after edge k+1.
- Edges k+2 .. k+1+DEBOUNCE_CYCLES see the mismatch (DEBOUNCE_CYCLES edges). key_level changes after edge k+1+DEBOUNCE_CYCLES.
- key_press/key_release are high for the one cycle after that edge, coincident with the first cycle of the new key_level.
- press_flag rises one edge after key_press rises, i.e. in the cycle after the pulse.
- ack sampled at edge m clears press_flag after edge m.
- All outputs are registered. No combinational path from any input to any output.
- Minimum spacing between accepted events on one key: DEBOUNCE_CYCLES edges.

## Test plan
Use DEBOUNCE_CYCLES=4.
- Reset, key_n=2'b11 idle for 20 cycles -> all outputs 0 throughout.
- key_n[0] falls and is held, sampled at edge 10 -> key_level[0]=1 after edge 15; key_press[0]=1 only in the cycle after edge 15; press_flag[0]=1 after edge 16; key 1 unaffected.
- Bounce: key_n[0] low for 3 synced cycles, high for 1, then low -> no pulse during the bounce. Counter restarts, and acceptance comes 4 mismatch edges after the final fall.
- Release of a pressed key after a stable low -> key_release[0] one-cycle pulse 5 edges after the sampling edge; key_level[0]=0; press_flag unchanged.
- ack[0] asserted in the same cycle key_press[0] sets the flag -> press_flag[0]=1. A single ack one cycle later -> press_flag[0]=0.
- Reset asserted while counter=2 with the key held, then released -> outputs 0 immediately (asynchronously). key_press fires 5 edges after the first post-reset edge that samples the held key.

Source files
------------

// File: rtl/key_debounce.sv
// Active-low push-button conditioner: per-key two-flop synchronizer, stability-count
// debounce, press/release pulses and a sticky press flag with per-key acknowledge.

module key_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic i_key_n,
    input  logic i_ack,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_flag
);
    localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_level;
    logic                 r_press;
    logic                 r_release;
    logic                 r_flag;

    logic w_diff;
    logic w_accept;

    assign w_diff   = r_sync2 ^ r_level;
    assign w_accept = w_diff && (r_cnt == LP_LAST);

    // Sync stages reset to 0, matching the inverted idle (released) key.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= ~i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    // Any return to the accepted level before the count completes restarts it;
    // the acceptance compare is what keeps the counter from ever wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= w_accept & ~r_level;
            r_release <= w_accept &  r_level;
            if (w_accept) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else if (w_diff) begin
                r_cnt   <= r_cnt + CNT_WIDTH'(1);
            end else begin
                r_cnt   <= '0;
            end
        end
    end

    // A press on the same edge as ack wins, so no press is ever lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_flag <= 1'b0;
        else       r_flag <= r_press | (r_flag & ~i_ack);
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_flag    = r_flag;
endmodule

module key_debounce #(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic [NUM_KEYS-1:0] ack,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] press_flag
);
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        key_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_WIDTH      (CNT_WIDTH)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .i_key_n  (key_n[gi]),
            .i_ack    (ack[gi]),
            .o_level  (key_level[gi]),
            .o_press  (key_press[gi]),
            .o_release(key_release[gi]),
            .o_flag   (press_flag[gi])
        );
    end
endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: a sliding-window debounce model checked every
// cycle, plus hand-computed literal expectations at the key timing points.

module tb_key_debounce;
    localparam int NK = 2;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] key_n;
    logic [NK-1:0] ack;
    logic [NK-1:0] key_level, key_press, key_release, press_flag;

    int n_vec = 0;
    int n_err = 0;

    key_debounce #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(D), .CNT_WIDTH(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_n      (key_n),
        .ack        (ack),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .press_flag (press_flag)
    );

    always #5 clk = ~clk;

    // Model: a level change is accepted when the last D synchronized samples all
    // disagree with the level and all D were seen since the previous acceptance.
    logic [NK-1:0] m_s1, m_s2, m_lvl, m_prs, m_rel, m_flg;
    logic [D-1:0]  m_win  [NK];
    int            m_age  [NK];
    logic [D-1:0]  n_win  [NK];
    int            n_age  [NK];
    logic [NK-1:0] n_acc;

    always_comb begin
        n_acc = '0;
        for (int k = 0; k < NK; k++) begin
            n_win[k] = {m_win[k][D-2:0], m_s2[k]};
            n_age[k] = (m_age[k] < D) ? m_age[k] + 1 : D;
            n_acc[k] = (n_age[k] >= D) && (n_win[k] == {D{~m_lvl[k]}});
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_s1 <= '0; m_s2 <= '0; m_lvl <= '0; m_prs <= '0; m_rel <= '0; m_flg <= '0;
            for (int k = 0; k < NK; k++) begin
                m_win[k] <= '0;
                m_age[k] <= 0;
            end
        end else begin
            m_s1  <= ~key_n;
            m_s2  <= m_s1;
            m_prs <= n_acc & ~m_lvl;
            m_rel <= n_acc &  m_lvl;
            m_lvl <= m_lvl ^ n_acc;
            m_flg <= m_prs | (m_flg & ~ack);
            for (int k = 0; k < NK; k++) begin
                m_win[k] <= n_win[k];
                m_age[k] <= n_acc[k] ? 0 : n_age[k];
            end
        end
    end

    initial forever begin
        @(negedge clk);
        n_vec++;
        if ({key_level, key_press, key_release, press_flag} !== {m_lvl, m_prs, m_rel, m_flg}) begin
            n_err++;
            $display("FAIL model t=%0t lvl/prs/rel/flg got=%b/%b/%b/%b exp=%b/%b/%b/%b", $time,
                     key_level, key_press, key_release, press_flag, m_lvl, m_prs, m_rel, m_flg);
        end
    end

    task automatic chk(input string nm, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%b exp=%b", nm, $time, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; key_n = 2'b11; ack = 2'b00;
        tick(3);
        reset = 1'b0;
        tick(20);
        chk("idle_level", |key_level, 1'b0);
        chk("idle_flag",  |press_flag, 1'b0);

        // Clean press on key 0: accepted 5 edges after the sampling edge.
        key_n = 2'b10;
        tick(5);
        chk("press_early_lvl", key_level[0], 1'b0);
        chk("press_early_prs", key_press[0], 1'b0);
        tick(1);
        chk("press_lvl",  key_level[0], 1'b1);
        chk("press_prs",  key_press[0], 1'b1);
        chk("press_flg0", press_flag[0], 1'b0);
        chk("key1_quiet", key_level[1], 1'b0);
        tick(1);
        chk("press_prs_end", key_press[0], 1'b0);
        chk("press_flg1",    press_flag[0], 1'b1);

        // Release leaves the sticky flag alone.
        tick(3);
        key_n = 2'b11;
        tick(5);
        chk("rel_early_lvl", key_level[0], 1'b1);
        tick(1);
        chk("rel_lvl", key_level[0], 1'b0);
        chk("rel_pls", key_release[0], 1'b1);
        chk("rel_flg", press_flag[0], 1'b1);
        tick(1);
        chk("rel_pls_end", key_release[0], 1'b0);

        ack = 2'b01;
        tick(1);
        chk("ack_clear", press_flag[0], 1'b0);
        ack = 2'b00;
        tick(2);

        // Bounce: 3 pressed samples, 1 released, then pressed for good.
        key_n = 2'b10;
        tick(3);
        key_n = 2'b11;
        tick(1);
        key_n = 2'b10;
        tick(5);
        chk("bounce_lvl_hold", key_level[0], 1'b0);
        chk("bounce_no_prs",   key_press[0], 1'b0);
        tick(1);
        chk("bounce_lvl", key_level[0], 1'b1);
        chk("bounce_prs", key_press[0], 1'b1);
        tick(2);

        // Key 1 press with ack on the edge that sets the flag: set wins.
        key_n = 2'b00;
        tick(6);
        chk("k1_prs", key_press[1], 1'b1);
        ack = 2'b10;
        tick(1);
        chk("ack_vs_set", press_flag[1], 1'b1);
        ack = 2'b00;
        tick(1);
        chk("k1_flag_hold", press_flag[1], 1'b1);
        ack = 2'b10;
        tick(1);
        chk("k1_ack_clear", press_flag[1], 1'b0);
        ack = 2'b00;

        // Release key 0, re-press it, and reset mid-count.
        key_n = 2'b01;
        tick(8);
        chk("k0_rel_lvl", key_level[0], 1'b0);
        key_n = 2'b00;
        tick(4);
        #2 reset = 1'b1;
        #1;
        chk("rst_lvl0", key_level[0], 1'b0);
        chk("rst_lvl1", key_level[1], 1'b0);
        chk("rst_flg0", press_flag[0], 1'b0);
        tick(1);
        reset = 1'b0;
        tick(5);
        chk("post_rst_early", key_level[0], 1'b0);
        tick(1);
        chk("post_rst_lvl0", key_level[0], 1'b1);
        chk("post_rst_prs0", key_press[0], 1'b1);
        chk("post_rst_prs1", key_press[1], 1'b1);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
